// File: rtl/data_memory_stage.sv
// data_memory_stage: memory-access stage of the 16-bit MIPS pipeline.
// Performs a word load or store on an internal 2**ADDR_W x 16 data memory,
// or passes the ALU result through, into a one-cycle pipeline register that
// feeds write-back. Honours stall (hold + no write) and bubbles (valid_ex=0).
// Optional feature macro: DM_BOUNDS_CHECK_EN (flags accesses whose upper
// address bits are non-zero; without it the address wraps modulo depth).
module data_memory_stage #(
   parameter int ADDR_W = 8,
   parameter int RD_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_ex,
   input  logic [15:0]       ans_ex,
   input  logic [15:0]       store_data_ex,
   input  logic              mem_rd_ex,
   input  logic              mem_wr_ex,
   input  logic [RD_W-1:0]   rd_ex,
   input  logic              reg_wr_ex,
   input  logic              stall,
   output logic [15:0]       ans_dm,
   output logic [RD_W-1:0]   rd_dm,
   output logic              reg_wr_dm,
   output logic              valid_dm,
   output logic              mem_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [15:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] addr_s;
   logic              oob_s;
   logic              mem_we_s;
   logic [15:0]       rd_word_s;

   logic [15:0]       ans_q,    ans_d;
   logic [RD_W-1:0]   rd_q,     rd_d;
   logic              reg_wr_q, reg_wr_d;
   logic              valid_q,  valid_d;
   logic              err_q,    err_d;

   assign addr_s    = ans_ex[ADDR_W-1:0];
   assign rd_word_s = mem_q[addr_s];

`ifdef DM_BOUNDS_CHECK_EN
   // Out-of-range detection: any memory op with non-zero upper address bits.
   always_comb begin
      oob_s = 1'b0;
      if ((mem_rd_ex || mem_wr_ex) && (ans_ex[15:ADDR_W] != '0)) begin
         oob_s = 1'b1;
      end else begin
         oob_s = 1'b0;
      end
   end
`else
   // Upper address bits are ignored, so no access is ever out of range.
   assign oob_s = 1'b0;
`endif

   // Memory write only for a valid, unstalled, in-range store.
   assign mem_we_s = valid_ex && mem_wr_ex && !stall && !oob_s;

   // Next-state of the DM pipeline register; a set write flag always wins over read.
   always_comb begin
      ans_d    = 16'h0000;
      rd_d     = '0;
      reg_wr_d = 1'b0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (!valid_ex) begin
         ans_d    = 16'h0000;
         rd_d     = '0;
         reg_wr_d = 1'b0;
         valid_d  = 1'b0;
         err_d    = 1'b0;
      end else begin
         valid_d = 1'b1;
         rd_d    = rd_ex;
         err_d   = oob_s;
         case ({mem_wr_ex, mem_rd_ex})
            2'b10, 2'b11: begin
               ans_d    = ans_ex;
               reg_wr_d = 1'b0;
            end
            2'b01: begin
               if (oob_s) begin
                  ans_d    = 16'h0000;
                  reg_wr_d = 1'b0;
               end else begin
                  ans_d    = rd_word_s;
                  reg_wr_d = reg_wr_ex;
               end
            end
            default: begin
               ans_d    = ans_ex;
               reg_wr_d = reg_wr_ex;
            end
         endcase
      end
   end

   // DM pipeline register: synchronous clear, hold on stall, else load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ans_q    <= 16'h0000;
         rd_q     <= '0;
         reg_wr_q <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else if (!stall) begin
         ans_q    <= ans_d;
         rd_q     <= rd_d;
         reg_wr_q <= reg_wr_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   // Data memory: cleared by reset, written on a committed store.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 16'h0000;
         end
      end else if (mem_we_s) begin
         mem_q[addr_s] <= store_data_ex;
      end
   end

   assign ans_dm    = ans_q;
   assign rd_dm     = rd_q;
   assign reg_wr_dm = reg_wr_q;
   assign valid_dm  = valid_q;
   assign mem_err   = err_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: table of directed vectors plus
// a hand-written sequence covering address range / wrap behaviour.
module tb_data_memory_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_ex;
   logic [15:0] ans_ex;
   logic [15:0] store_data_ex;
   logic        mem_rd_ex;
   logic        mem_wr_ex;
   logic [2:0]  rd_ex;
   logic        reg_wr_ex;
   logic        stall;
   logic [15:0] ans_dm;
   logic [2:0]  rd_dm;
   logic        reg_wr_dm;
   logic        valid_dm;
   logic        mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   data_memory_stage #(.ADDR_W(8), .RD_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_ex      (valid_ex),
      .ans_ex        (ans_ex),
      .store_data_ex (store_data_ex),
      .mem_rd_ex     (mem_rd_ex),
      .mem_wr_ex     (mem_wr_ex),
      .rd_ex         (rd_ex),
      .reg_wr_ex     (reg_wr_ex),
      .stall         (stall),
      .ans_dm        (ans_dm),
      .rd_dm         (rd_dm),
      .reg_wr_dm     (reg_wr_dm),
      .valid_dm      (valid_dm),
      .mem_err       (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        stl;
      logic        vld;
      logic        rdop;
      logic        wrop;
      logic [15:0] ans;
      logic [15:0] sd;
      logic [2:0]  rd;
      logic        rw;
      logic [15:0] e_ans;
      logic [2:0]  e_rd;
      logic        e_rw;
      logic        e_vld;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst_n, input logic stl, input logic vld,
                               input logic rdop, input logic wrop, input logic [15:0] ans,
                               input logic [15:0] sd, input logic [2:0] rd, input logic rw,
                               input logic [15:0] e_ans, input logic [2:0] e_rd,
                               input logic e_rw, input logic e_vld, input logic e_err);
      vec_t v;
      v.rst_n = rst_n; v.stl = stl; v.vld = vld; v.rdop = rdop; v.wrop = wrop;
      v.ans = ans; v.sd = sd; v.rd = rd; v.rw = rw;
      v.e_ans = e_ans; v.e_rd = e_rd; v.e_rw = e_rw; v.e_vld = e_vld; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector, clock one edge, then compare all outputs.
   task automatic apply(input vec_t v, input string tag);
      reset         = v.rst_n;
      stall         = v.stl;
      valid_ex      = v.vld;
      mem_rd_ex     = v.rdop;
      mem_wr_ex     = v.wrop;
      ans_ex        = v.ans;
      store_data_ex = v.sd;
      rd_ex         = v.rd;
      reg_wr_ex     = v.rw;
      @(posedge clk);
      #1;
      chk({tag, ".ans_dm"},    ans_dm,             v.e_ans);
      chk({tag, ".rd_dm"},     {13'h0, rd_dm},     {13'h0, v.e_rd});
      chk({tag, ".reg_wr_dm"}, {15'h0, reg_wr_dm}, {15'h0, v.e_rw});
      chk({tag, ".valid_dm"},  {15'h0, valid_dm},  {15'h0, v.e_vld});
      chk({tag, ".mem_err"},   {15'h0, mem_err},   {15'h0, v.e_err});
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; valid_ex = 1'b0; mem_rd_ex = 1'b0; mem_wr_ex = 1'b0;
      ans_ex = 16'h0000; store_data_ex = 16'h0000; rd_ex = 3'd0; reg_wr_ex = 1'b0;
      #2;

      //              rst   stl   vld   rd    wr    ans       sd        rd    rw      e_ans     e_rd  e_rw  e_v   e_err
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0)); // reset
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h1234, 3'd1, 1'b1, 16'h0005, 3'd1, 1'b0, 1'b1, 1'b0)); // store mem[5]
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0006, 16'h9999, 3'd1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0)); // reset beats store
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'd1, 1'b1, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0)); // mem cleared
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0006, 16'h0000, 3'd2, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0)); // not written
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 3'd2, 1'b1, 16'h0010, 3'd2, 1'b0, 1'b1, 1'b0)); // store BEEF
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd3, 1'b1, 16'hBEEF, 3'd3, 1'b1, 1'b1, 1'b0)); // load back
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 3'd4, 1'b1, 16'h7FFF, 3'd4, 1'b1, 1'b1, 1'b0)); // pass-through
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hDEAD, 3'd7, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0)); // bubble store
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd1, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0)); // bubble no write
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h0042, 3'd5, 1'b1, 16'h0007, 3'd5, 1'b0, 1'b1, 1'b0)); // rd+wr = store
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000, 3'd5, 1'b1, 16'h0042, 3'd5, 1'b1, 1'b1, 1'b0)); // mem[7]=42
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h0000, 3'd6, 1'b1, 16'h3333, 3'd6, 1'b1, 1'b1, 1'b0)); // pass
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h3333, 3'd6, 1'b1, 1'b1, 1'b0)); // stall hold
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h3333, 3'd6, 1'b1, 1'b1, 1'b0)); // stall hold
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 3'd2, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0)); // no stalled write
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0)); // stall 1
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0)); // stall 2
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0)); // stall 3
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hAAAA, 3'd1, 1'b1, 16'h0002, 3'd1, 1'b0, 1'b1, 1'b0)); // release
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 3'd3, 1'b1, 16'hAAAA, 3'd3, 1'b1, 1'b1, 1'b0)); // written
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 16'hBBBB, 3'd3, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0)); // reset in stall
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 3'd3, 1'b1, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0)); // cleared

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Hand-written sequence: upper address bits and wrap at top of memory.
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h5555, 3'd1, 1'b0,
               16'h0005, 3'd1, 1'b0, 1'b1, 1'b0), "seq_st5");
`ifdef DM_BOUNDS_CHECK_EN
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0105, 16'h0000, 3'd6, 1'b1,
               16'h0000, 3'd6, 1'b0, 1'b1, 1'b1), "seq_ld105");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0205, 16'h7777, 3'd2, 1'b1,
               16'h0205, 3'd2, 1'b0, 1'b1, 1'b1), "seq_st205");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'd4, 1'b1,
               16'h5555, 3'd4, 1'b1, 1'b1, 1'b0), "seq_ld5");
`else
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0105, 16'h0000, 3'd6, 1'b1,
               16'h5555, 3'd6, 1'b1, 1'b1, 1'b0), "seq_ld105");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0205, 16'h7777, 3'd2, 1'b1,
               16'h0205, 3'd2, 1'b0, 1'b1, 1'b0), "seq_st205");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'd4, 1'b1,
               16'h7777, 3'd4, 1'b1, 1'b1, 1'b0), "seq_ld5");
`endif
      apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 16'hFFFF, 3'd0, 1'b0,
               16'h00FF, 3'd0, 1'b0, 1'b1, 1'b0), "seq_stFF");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 3'd7, 1'b1,
               16'hFFFF, 3'd7, 1'b1, 1'b1, 1'b0), "seq_ldFF");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd7, 1'b1,
               16'h0000, 3'd7, 1'b1, 1'b1, 1'b0), "seq_ld00");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
